// File: rtl/reg_file_sb.sv
// reg_file_sb: two-read / one-write register file with a busy-bit scoreboard.
// An issuing instruction marks its destination busy; writeback clears it.
// Reading a busy register raises a RAW stall. busy_cnt tracks how many
// registers are currently pending.
// Optional feature macro: REG_FILE_BYPASS_EN. When it is defined, data being
// written back in the current cycle is forwarded to the read ports, and that
// register no longer stalls.
module reg_file_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] a3,
   input  logic [DATA_W-1:0] wd,
   input  logic [ADDR_W-1:0] a1,
   input  logic [ADDR_W-1:0] a2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   input  logic              iss_en,
   input  logic [ADDR_W-1:0] iss_rd,
   output logic              stall,
   output logic [ADDR_W:0]   busy_cnt
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  busy;

   logic z1, z2, z3, zi;
   logic fwd1, fwd2;
   logic wr_ok, iss_ok;
   logic cnt_inc, cnt_dec;

   // Decode which addresses refer to the hardwired zero register.
   always_comb begin
      z1 = (ZERO_REG != 0) && (a1 == '0);
      z2 = (ZERO_REG != 0) && (a2 == '0);
      z3 = (ZERO_REG != 0) && (a3 == '0);
      zi = (ZERO_REG != 0) && (iss_rd == '0);
   end

   // Forwarding selects. Reset gates them so outputs read as zero during reset.
   always_comb begin
`ifdef REG_FILE_BYPASS_EN
      fwd1 = !rst && wr_en && !z3 && (a3 == a1);
      fwd2 = !rst && wr_en && !z3 && (a3 == a2);
`else
      fwd1 = 1'b0;
      fwd2 = 1'b0;
`endif
   end

   // Read ports: zero register, then forwarded data, then stored contents.
   always_comb begin
      rd1 = z1 ? '0 : (fwd1 ? wd : regs[a1]);
      rd2 = z2 ? '0 : (fwd2 ? wd : regs[a2]);
   end

   // RAW hazard. A busy bit is never set on the zero register, so an explicit
   // zero-register mask is not required here.
   always_comb begin
      stall = (busy[a1] & ~fwd1) | (busy[a2] & ~fwd2);
   end

   // Accepted actions and their effect on the busy count. When an issue and a
   // writeback hit the same address, the issue wins and the bit stays set.
   always_comb begin
      wr_ok   = wr_en && !z3;
      iss_ok  = iss_en && !stall && !zi;
      cnt_inc = iss_ok && !busy[iss_rd];
      cnt_dec = wr_ok && busy[a3] && !(iss_ok && (iss_rd == a3));
   end

   // Storage, busy bits and busy count. Write clears first, issue sets last.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
         busy     <= '0;
         busy_cnt <= '0;
      end else begin
         if (wr_ok) begin
            regs[a3] <= wd;
            if (!(iss_ok && (iss_rd == a3))) busy[a3] <= 1'b0;
         end
         if (iss_ok) busy[iss_rd] <= 1'b1;
         busy_cnt <= busy_cnt + (ADDR_W+1)'(cnt_inc) - (ADDR_W+1)'(cnt_dec);
      end
   end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed steps from the test plan,
// then randomized traffic compared against a rule-level reference model.
module tb_reg_file_sb;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              wr_en;
   logic [ADDR_W-1:0] a3;
   logic [DATA_W-1:0] wd;
   logic [ADDR_W-1:0] a1;
   logic [ADDR_W-1:0] a2;
   logic [DATA_W-1:0] rd1;
   logic [DATA_W-1:0] rd2;
   logic              iss_en;
   logic [ADDR_W-1:0] iss_rd;
   logic              stall;
   logic [ADDR_W:0]   busy_cnt;

   reg_file_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .a3(a3), .wd(wd),
      .a1(a1), .a2(a2), .rd1(rd1), .rd2(rd2),
      .iss_en(iss_en), .iss_rd(iss_rd), .stall(stall), .busy_cnt(busy_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: plain arrays of values and pending flags.
   logic [DATA_W-1:0] mreg  [DEPTH];
   bit                mbusy [DEPTH];

   int vectors = 0;
   int miscompares = 0;

`ifdef REG_FILE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit m_fwd(input int a);
      return BYPASS && wr_en && (int'(a3) == a) && (a != 0);
   endfunction

   function automatic logic [DATA_W-1:0] m_rd(input int a);
      if (a == 0) return '0;
      if (m_fwd(a)) return wd;
      return mreg[a];
   endfunction

   function automatic bit m_stall();
      return (mbusy[a1] && !m_fwd(int'(a1))) || (mbusy[a2] && !m_fwd(int'(a2)));
   endfunction

   function automatic int m_cnt();
      int n = 0;
      for (int i = 0; i < DEPTH; i++) n += int'(mbusy[i]);
      return n;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < DEPTH; i++) begin
         mreg[i]  = '0;
         mbusy[i] = 1'b0;
      end
   endtask

   task automatic idle();
      wr_en = 0; a3 = '0; wd = '0; iss_en = 0; iss_rd = '0; a1 = '0; a2 = '0;
   endtask

   // One clock cycle: check outputs mid-cycle, then advance the model with the edge.
   task automatic cyc(input string tag);
      logic [DATA_W-1:0] nreg [DEPTH];
      bit                nbusy [DEPTH];
      bit                st;
      #3;
      st = m_stall();
      chk({tag, ".rd1"}, rd1, m_rd(int'(a1)));
      chk({tag, ".rd2"}, rd2, m_rd(int'(a2)));
      chk({tag, ".stall"}, {31'd0, stall}, {31'd0, st});
      chk({tag, ".cnt"}, {26'd0, busy_cnt}, DATA_W'(m_cnt()));
      for (int i = 0; i < DEPTH; i++) begin
         nreg[i]  = mreg[i];
         nbusy[i] = mbusy[i];
      end
      if (wr_en && a3 != 0) begin
         nreg[a3]  = wd;
         nbusy[a3] = 1'b0;
      end
      if (iss_en && !st && iss_rd != 0) nbusy[iss_rd] = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < DEPTH; i++) begin
         mreg[i]  = nreg[i];
         mbusy[i] = nbusy[i];
      end
   endtask

   initial begin
      idle();
      m_reset();

      // Reset then read.
      rst = 1; a1 = 5'd7; a2 = 5'd31;
      #2;
      chk("rst.rd1", rd1, '0);
      chk("rst.rd2", rd2, '0);
      chk("rst.stall", {31'd0, stall}, '0);
      chk("rst.cnt", {26'd0, busy_cnt}, '0);
      @(posedge clk); #1;
      rst = 0;

      // Basic write then read.
      idle(); wr_en = 1; a3 = 5'd5; wd = 32'hDEADBEEF;
      cyc("wr5");
      idle(); a1 = 5'd5;
      cyc("rd5");
      chk("rd5.const", rd1, 32'hDEADBEEF);

      // Zero register: write and issue both dropped.
      idle(); wr_en = 1; a3 = '0; wd = 32'h1234; iss_en = 1; iss_rd = '0;
      cyc("zero.op");
      idle();
      cyc("zero.rd");
      chk("zero.cnt", {26'd0, busy_cnt}, '0);

      // RAW stall and writeback.
      idle(); iss_en = 1; iss_rd = 5'd3;
      cyc("raw.iss");
      idle(); a1 = 5'd3;
      #2;
      chk("raw.stall1", {31'd0, stall}, 32'd1);
      chk("raw.cnt1", {26'd0, busy_cnt}, 32'd1);
      #1; cyc("raw.hold");
      idle(); a1 = 5'd3; wr_en = 1; a3 = 5'd3; wd = 32'h55;
      cyc("raw.wb");
      idle(); a1 = 5'd3;
      cyc("raw.after");
      chk("raw.rd55", rd1, 32'h55);

      // Issue and write to the same address: issue wins.
      idle(); iss_en = 1; iss_rd = 5'd9; wr_en = 1; a3 = 5'd9; wd = 32'h99;
      cyc("coll");
      idle();
      cyc("coll.after");
      chk("coll.cnt", {26'd0, busy_cnt}, 32'd1);

      // Issue while stalled is ignored.
      idle(); a1 = 5'd9; iss_en = 1; iss_rd = 5'd10;
      cyc("ign");
      idle();
      cyc("ign.after");
      chk("ign.cnt", {26'd0, busy_cnt}, 32'd1);

      // WAW issue to an already busy register.
      idle(); iss_en = 1; iss_rd = 5'd9;
      cyc("waw");
      idle(); iss_en = 1; iss_rd = 5'd11; cyc("b11");
      idle(); iss_en = 1; iss_rd = 5'd12; cyc("b12");
      idle(); iss_en = 1; iss_rd = 5'd13; cyc("b13");
      idle(); a1 = 5'd5; a2 = 5'd9;
      #2;
      chk("pre.cnt4", {26'd0, busy_cnt}, 32'd4);

      // Asynchronous reset between edges, with a write in flight.
      wr_en = 1; a3 = 5'd14; wd = 32'hCAFE;
      rst = 1;
      #1;
      m_reset();
      chk("arst.cnt", {26'd0, busy_cnt}, '0);
      chk("arst.stall", {31'd0, stall}, '0);
      chk("arst.rd1", rd1, '0);
      chk("arst.rd2", rd2, '0);
      @(posedge clk); #1;
      rst = 0;
      idle(); a1 = 5'd14; a2 = 5'd5;
      cyc("arst.after");

      // Randomized traffic on a narrow address window to provoke hazards.
      for (int n = 0; n < 400; n++) begin
         idle();
         wr_en  = 1'($urandom_range(0, 1));
         a3     = 5'($urandom_range(0, 7));
         wd     = $urandom;
         iss_en = 1'($urandom_range(0, 1));
         iss_rd = 5'($urandom_range(0, 7));
         a1     = 5'($urandom_range(0, 9));
         a2     = 5'($urandom_range(0, 31));
         cyc("rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
